// File: rtl/layer_input_serializer.sv
// -----------------------------------------------------------------------------
// layer_input_serializer
//
// Takes a whole parallel activation vector from the host or previous stage.
// Sends it out one word per clock on x, in a framing that a layer instance can
// consume directly:
//   - sof/eof mark the first and last word of each frame.
//   - idx is the element index.
//   - GAP idle cycles follow each frame so the layer can store and clear.
//
// Storage:
//   - active  : shift register holding the frame currently being sent.
//   - pending : one-entry buffer (with pend_full) holding the next vector.
//
// Ports:
//   clk       clock; all state changes on the rising edge
//   rst       asynchronous reset, active-high
//   in_valid  producer has a vector on in_data
//   in_ready  block can accept a vector this cycle (registered)
//   in_data   packed vector, element i at [i*BIT_SIZE +: BIT_SIZE]
//   x         serial word, 0 when x_valid=0
//   x_valid   x carries a vector element this cycle
//   idx       index of the element on x, 0 when x_valid=0
//   sof       first element of a frame is on x
//   eof       last element of a frame is on x
//   busy      a frame or gap is in progress, or a vector is pending
//
// Handshake (valid/ready):
//   - A vector transfers on a rising edge where in_valid && in_ready.
//   - in_data is sampled only on that edge.
//   - in_ready is a register equal to !pend_full as it will be after the edge.
//     It therefore never depends combinationally on in_valid.
//   - A producer holding in_valid high while in_ready=0 has no effect.
// -----------------------------------------------------------------------------
module layer_input_serializer #(
  parameter int IN_SIZE  = 3,
  parameter int BIT_SIZE = 1,
  parameter int GAP      = 2
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [IN_SIZE*BIT_SIZE-1:0]                       in_data,
  output logic [BIT_SIZE-1:0]                               x,
  output logic                                              x_valid,
  output logic [((IN_SIZE > 1) ? $clog2(IN_SIZE) : 1)-1:0]  idx,
  output logic                                              sof,
  output logic                                              eof,
  output logic                                              busy
);

  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int VW = IN_SIZE * BIT_SIZE;

  localparam logic [IW-1:0] LAST_IDX = IW'(IN_SIZE - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [VW-1:0]   active, active_n;
  logic [VW-1:0]   pending, pending_n;
  logic            pend_full, pend_full_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [GW-1:0]   gap_cnt, gap_n;
  logic            xfer;
  logic            advance;  // active becomes free on this edge

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      idx_q     <= '0;
      gap_cnt   <= '0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_n;
      active    <= active_n;
      pending   <= pending_n;
      pend_full <= pend_full_n;
      idx_q     <= idx_n;
      gap_cnt   <= gap_n;
      in_ready  <= !pend_full_n;
    end
  end

  always_comb begin
    state_n     = state;
    active_n    = active;
    pending_n   = pending;
    pend_full_n = pend_full;
    idx_n       = idx_q;
    gap_n       = gap_cnt;
    advance     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (xfer) begin
          active_n = in_data;
          idx_n    = '0;
          state_n  = ST_SEND;
        end
      end

      ST_SEND: begin
        active_n = active >> BIT_SIZE;
        idx_n    = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          idx_n = '0;
          if (GAP > 0) begin
            state_n = ST_GAP;
            gap_n   = '0;
            if (xfer) begin
              pending_n   = in_data;
              pend_full_n = 1'b1;
            end
          end else begin
            advance = 1'b1;
          end
        end else if (xfer) begin
          pending_n   = in_data;
          pend_full_n = 1'b1;
        end
      end

      ST_GAP: begin
        gap_n = gap_cnt + GW'(1);
        if (gap_cnt == GAP_LAST) begin
          advance = 1'b1;
        end else if (xfer) begin
          pending_n   = in_data;
          pend_full_n = 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // The active register is free. The pending vector goes first. Otherwise a
    // vector arriving on this very edge goes straight to active, so no cycle
    // is lost. (pend_full=1 implies in_ready=0, so both cannot happen.)
    if (advance) begin
      idx_n = '0;
      if (pend_full) begin
        active_n    = pending;
        pend_full_n = 1'b0;
        state_n     = ST_SEND;
      end else if (xfer) begin
        active_n = in_data;
        state_n  = ST_SEND;
      end else begin
        state_n = ST_IDLE;
      end
    end
  end

  assign x_valid = (state == ST_SEND);
  assign x       = x_valid ? active[BIT_SIZE-1:0] : '0;
  assign idx     = x_valid ? idx_q : '0;
  assign sof     = x_valid && (idx_q == '0);
  assign eof     = x_valid && (idx_q == LAST_IDX);
  assign busy    = (state != ST_IDLE) || pend_full;

endmodule

// File: tb/tb_layer_input_serializer.sv
// -----------------------------------------------------------------------------
// tb_layer_input_serializer
//
// Three instances share one clock and one reset:
//   u0 : IN_SIZE=3, GAP=2
//   u1 : IN_SIZE=3, GAP=0
//   u2 : IN_SIZE=1, GAP=1
// All three use BIT_SIZE=4.
//
// The reference model is a transmission schedule. Each accepted vector gets a
// start cycle: the cycle after acceptance, or the first cycle after the
// previous frame and its gap, whichever is later. From that schedule every
// output is derived for each cycle:
//   - x, idx, sof, eof from the frame covering the cycle.
//   - in_ready from whether a scheduled vector is still waiting to start.
//   - busy from the end of the last scheduled frame plus its gap.
// -----------------------------------------------------------------------------
module tb_layer_input_serializer;

  localparam int BW = 4;
  localparam int NI = 3;
  localparam int MAXF = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid [NI];
  logic [11:0] in_data  [NI];
  logic        in_ready_o [NI];
  logic [3:0]  x_o      [NI];
  logic        x_valid_o[NI];
  logic [1:0]  idx_o    [NI];
  logic        sof_o    [NI];
  logic        eof_o    [NI];
  logic        busy_o   [NI];
  logic        idx2;

  assign idx_o[2] = {1'b0, idx2};

  layer_input_serializer #(.IN_SIZE(3), .BIT_SIZE(BW), .GAP(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_o[0]),
    .in_data(in_data[0]), .x(x_o[0]), .x_valid(x_valid_o[0]), .idx(idx_o[0]),
    .sof(sof_o[0]), .eof(eof_o[0]), .busy(busy_o[0]));

  layer_input_serializer #(.IN_SIZE(3), .BIT_SIZE(BW), .GAP(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_o[1]),
    .in_data(in_data[1]), .x(x_o[1]), .x_valid(x_valid_o[1]), .idx(idx_o[1]),
    .sof(sof_o[1]), .eof(eof_o[1]), .busy(busy_o[1]));

  layer_input_serializer #(.IN_SIZE(1), .BIT_SIZE(BW), .GAP(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_o[2]),
    .in_data(in_data[2][3:0]), .x(x_o[2]), .x_valid(x_valid_o[2]), .idx(idx2),
    .sof(sof_o[2]), .eof(eof_o[2]), .busy(busy_o[2]));

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  int          in_sz  [NI] = '{3, 3, 1};
  int          gap_sz [NI] = '{2, 0, 1};
  int          cyc;
  int          last_start [NI];
  bit          ready_en   [NI];
  bit          acc        [NI];
  int          nf   [NI];
  int          head [NI];
  int          sstart [NI][MAXF];
  logic [11:0] svec   [NI][MAXF];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int i);
    return ready_en[i] && !(last_start[i] > cyc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      ready_en[i]   = 1'b0;
      head[i]       = nf[i];
      last_start[i] = -1000;
      acc[i]        = 1'b0;
    end
  endtask

  // Called right after each rising edge; cyc is the cycle that just ended.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      acc[i] = 1'b0;
      if (rst) begin
        ready_en[i]   = 1'b0;
        head[i]       = nf[i];
        last_start[i] = -1000;
      end else begin
        if (in_valid[i] && m_ready(i)) begin
          int s;
          s = cyc + 1;
          if (last_start[i] + in_sz[i] + gap_sz[i] > s)
            s = last_start[i] + in_sz[i] + gap_sz[i];
          if (nf[i] < MAXF) begin
            sstart[i][nf[i]] = s;
            svec[i][nf[i]]   = in_data[i];
            nf[i]++;
          end
          last_start[i] = s;
          acc[i]        = 1'b1;
        end
        ready_en[i] = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      bit          v;
      int          e;
      logic [3:0]  ex;
      while (head[i] < nf[i] && sstart[i][head[i]] + in_sz[i] <= cyc) head[i]++;
      v  = (head[i] < nf[i]) && (sstart[i][head[i]] <= cyc);
      e  = v ? cyc - sstart[i][head[i]] : 0;
      ex = v ? 4'((svec[i][head[i]] >> (e * BW)) & 12'hF) : 4'h0;
      check($sformatf("x_valid[%0d]", i), 32'(x_valid_o[i]), 32'(v));
      check($sformatf("x[%0d]", i), 32'(x_o[i]), 32'(ex));
      check($sformatf("idx[%0d]", i), 32'(idx_o[i]), 32'(e));
      check($sformatf("sof[%0d]", i), 32'(sof_o[i]), 32'(v && e == 0));
      check($sformatf("eof[%0d]", i), 32'(eof_o[i]), 32'(v && e == in_sz[i] - 1));
      check($sformatf("in_ready[%0d]", i), 32'(in_ready_o[i]), 32'(m_ready(i)));
      check($sformatf("busy[%0d]", i), 32'(busy_o[i]),
            32'(cyc < last_start[i] + in_sz[i] + gap_sz[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_vec(input int i, input logic [11:0] v);
    int n;
    in_valid[i] = 1'b1;
    in_data[i]  = v;
    n = 0;
    forever begin
      step();
      n++;
      if (acc[i] || n >= 60) break;
    end
    if (!acc[i]) check($sformatf("accept_timeout[%0d]", i), 32'd0, 32'd1);
    in_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    repeat (2) step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      nf[i]       = 0;
    end
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // single vector {C,B,A} on the GAP=2 instance
    send_vec(0, 12'hCBA);
    repeat (8) step();

    // continuous vectors, frame every IN_SIZE+GAP cycles
    send_vec(0, 12'h321);
    send_vec(0, 12'h654);
    send_vec(0, 12'h987);
    repeat (16) step();

    // GAP=0: two frames back to back
    send_vec(1, 12'h1F2);
    send_vec(1, 12'hE3D);
    repeat (10) step();

    // data changes while pending is full
    send_vec(0, 12'hA5A);
    send_vec(0, 12'h5A5);
    in_valid[0] = 1'b1;
    repeat (5) begin
      in_data[0] = 12'($urandom);
      step();
    end
    in_valid[0] = 1'b0;
    repeat (14) step();

    // reset mid-frame with a vector pending
    send_vec(0, 12'h777);
    send_vec(0, 12'h888);
    do_reset();
    repeat (3) step();
    send_vec(0, 12'h4C2);
    repeat (8) step();

    // IN_SIZE=1, GAP=1: vectors 5 and 9
    send_vec(2, 12'h005);
    send_vec(2, 12'h009);
    repeat (6) step();

    // randomized traffic on all instances
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NI; i++) begin
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_data[i]  = 12'($urandom);
      end
      step();
    end
    for (int i = 0; i < NI; i++) in_valid[i] = 1'b0;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/layer_input_serializer.md
Name: layer_input_serializer

Overview:
- Transmit-side partner of the layer block's serial input: it accepts a whole parallel activation vector and streams it out one word per clock on x.
- Framing (sof/eof), an element index and inter-frame gaps match the layer's accumulate/store cadence, so x can drive a layer instance directly.
- It sits between the host/previous stage (parallel valid/ready) and the first layer of the network.

Parameters:
- IN_SIZE, 3, number of words per vector/frame (>=1)
- BIT_SIZE, 1, width of each word
- GAP, 2, idle cycles inserted after each frame's last word (>=0); lets the layer perform STORE/CLEAR

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  producer has a vector on in_data
- in_ready  output  1  block can accept a vector this cycle (registered)
- in_data  input  IN_SIZE*BIT_SIZE  packed vector; element i at bits [i*BIT_SIZE +: BIT_SIZE]; element 0 is sent first
- x  output  BIT_SIZE  serial word; 0 when x_valid=0
- x_valid  output  1  x carries a vector element this cycle
- idx  output  max(1,$clog2(IN_SIZE))  index of element on x; 0 when not valid
- sof  output  1  x_valid && idx==0
- eof  output  1  x_valid && idx==IN_SIZE-1
- busy  output  1  state != IDLE or pending buffer full

Behaviour:
- Storage:
  - active shift register of IN_SIZE words.
  - one-entry pending register plus a pend_full flag.
- Reset, asynchronous on rst=1:
  - state=IDLE; active, pending and pend_full cleared.
  - idx=0, gap counter=0.
  - x=0, x_valid=0, sof=0, eof=0, busy=0, in_ready=0.
  - in_ready goes to 1 on the first clk edge after rst deasserts.
  - Asserting rst mid-frame aborts the frame; the partial frame and any pending vector are discarded.
- Handshake:
  - Transfer when in_valid && in_ready at a rising edge.
  - in_ready is registered: in_ready = !pend_full_next.
  - The block never accepts while pend_full=1.
  - in_data is sampled only at the transfer edge.
- States: IDLE, SEND, GAP.
- IDLE:
  - On transfer, in_data loads directly into active; idx=0; state->SEND.
  - Element 0 appears on x in the cycle following the transfer edge (latency 1).
- SEND:
  - x = active[0] and x_valid=1.
  - Each edge shifts active down one word and increments idx.
  - A transfer in SEND writes pending and sets pend_full.
  - When idx==IN_SIZE-1:
    - If GAP>0, state->GAP and gap counter=0.
    - Else, if pend_full (registered at this edge), pending->active, pend_full cleared, idx=0, stay in SEND. The frames are back-to-back: eof is followed immediately by sof.
    - Else state->IDLE.
- GAP:
  - x_valid=0, x=0.
  - The counter increments each cycle; GAP cycles are spent here.
  - On the last gap cycle, if pend_full, pending->active, state->SEND, idx=0; else state->IDLE.
  - A transfer during GAP fills pending and is taken at the gap's end.
- Transfer while leaving IDLE:
  - If a transfer occurs on the same edge the state leaves IDLE, the vector goes to active.
  - pending is used only when active is occupied.
- Frame period with continuous input: IN_SIZE+GAP cycles per vector. Throughput is never reduced by the handshake.
- IN_SIZE=1: every valid word has sof=eof=1; the idx port is 1 bit and held at 0.
- in_valid held high with in_ready=0 must not change pending contents.
- No arithmetic; words pass unmodified, LSB-first packing as above.

Test Plan:
- Reset, then one vector (IN_SIZE=3, BIT_SIZE=4, GAP=2) in_data={C,B,A} (element0=A), accepted at edge k:
  - x=A,B,C with idx 0,1,2 in cycles k+1..k+3.
  - sof at k+1, eof at k+3.
  - x_valid=0 for k+4,k+5, then IDLE, busy=0.
- in_valid held high with vectors V0,V1,V2:
  - Frames every 5 cycles with no extra bubbles.
  - in_ready drops while pend_full=1 and rises the cycle after pending moves to active.
  - Order V0,V1,V2 is preserved.
- GAP=0, two vectors queued:
  - eof of frame 0 is immediately followed by sof of frame 1.
  - x stream = 6 contiguous valid words.
- Producer changes in_data while in_ready=0 (pending full):
  - The pending vector is unaffected.
  - The changed value is not transmitted unless it is re-presented once in_ready=1.
- rst pulsed mid-frame after element 1 of V0, with V1 pending:
  - All outputs go to 0 immediately.
  - After release, no remaining V0 or V1 words appear; the next accepted vector starts with sof.
- IN_SIZE=1, GAP=1, vectors 5,9 back-to-back:
  - x=5 (sof=eof=1), one gap cycle, then x=9 (sof=eof=1).
  - idx stays 0.
